// File: rtl/fetch_stage_pkg.sv
// Shared constants and next-PC selection for the instruction-fetch stage.
// The package constants supply the default parameter values of the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned    WIDTH_DEF     = 32;
    localparam logic [31:0]    RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0]    NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        PcHold,
        PcJump,
        PcBranch,
        PcSeq
    } pc_sel_e;

    // Hazard stall beats any redirect; a jump beats a taken branch.
    function automatic pc_sel_e pc_sel(logic stall, logic jump, logic branch);
        if (stall) return PcHold;
        if (jump) return PcJump;
        if (branch) return PcBranch;
        return PcSeq;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, memory and IF/ID signals between the fetch stage and the rest of the core.
// The slave modport is the fetch stage; the master modport is the surrounding core.
interface fetch_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             pcSrcD;
    logic             jumpD;
    logic [WIDTH-1:0] pcBranchD;
    logic [WIDTH-1:0] pcJumpD;
    logic [WIDTH-1:0] imemRdata;
    logic [WIDTH-1:0] imemAddr;
    logic [WIDTH-1:0] instrD;
    logic [WIDTH-1:0] pcPlus4D;
    logic             validD;

    modport master (
        output stallF, stallD, flushD, pcSrcD, jumpD, pcBranchD, pcJumpD, imemRdata,
        input  imemAddr, instrD, pcPlus4D, validD
    );

    modport slave (
        input  stallF, stallD, flushD, pcSrcD, jumpD, pcBranchD, pcJumpD, imemRdata,
        output imemAddr, instrD, pcPlus4D, validD
    );
endinterface

// File: rtl/fetch_stage_pipe_reg.sv
// Pipeline register with async active-low reset, hold enable and synchronous clear.
// Hold (en=0) takes precedence over clear, so a stalled stage cannot be flushed.
module fetch_stage_pipe_reg #(
    parameter int unsigned   W         = 32,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= clr ? RESET_VAL : d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// imemAddr depends only on the PC register; imemRdata reaches outputs only through flops.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC  = RESET_PC_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF[WIDTH-1:0]
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.slave bus
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4_f;
    logic [WIDTH-1:0] jump_target;
    logic             unused_jump_hi;

    assign pc_plus4_f  = pc_q + WIDTH'(4);
    // Jumps stay inside the 256 MB region of the instruction after the jump.
    assign jump_target = {bus.pcPlus4D[WIDTH-1:WIDTH-4], bus.pcJumpD[WIDTH-5:0]};
    assign unused_jump_hi = ^bus.pcJumpD[WIDTH-1:WIDTH-4];

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel(bus.stallF, bus.jumpD, bus.pcSrcD))
            PcHold:   pc_d = pc_q;
            PcJump:   pc_d = jump_target;
            PcBranch: pc_d = bus.pcBranchD;
            PcSeq:    pc_d = pc_plus4_f;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.imemAddr = pc_q;

    fetch_stage_pipe_reg #(
        .W         (WIDTH),
        .RESET_VAL (NOP_INSTR)
    ) u_instr_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stallD),
        .clr (bus.flushD),
        .d   (bus.imemRdata),
        .q   (bus.instrD)
    );

    fetch_stage_pipe_reg #(
        .W         (WIDTH),
        .RESET_VAL ('0)
    ) u_pc_plus4_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stallD),
        .clr (bus.flushD),
        .d   (pc_plus4_f),
        .q   (bus.pcPlus4D)
    );

    fetch_stage_pipe_reg #(
        .W         (1),
        .RESET_VAL (1'b0)
    ) u_valid_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stallD),
        .clr (bus.flushD),
        .d   (1'b1),
        .q   (bus.validD)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID and PC state is queued per step and
// compared one cycle later against the outputs.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_stage_if #(.WIDTH(32)) bus ();

    fetch_stage #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: fixed word at 0, otherwise an address-unique pattern.
    function automatic logic [31:0] mem_f(logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'h8C00_0000);
    endfunction

    assign bus.imemRdata = mem_f(bus.imemAddr);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".imemAddr"}, bus.imemAddr, e.addr);
        check({tag, ".instrD"},   bus.instrD,   e.instr);
        check({tag, ".pcPlus4D"}, bus.pcPlus4D, e.pc4);
        check({tag, ".validD"},   {31'b0, bus.validD}, {31'b0, e.v});
    endtask

    // Drive controls for one cycle; expectations hold just after the next rising edge.
    task automatic step(input string tag, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic jd, input logic [31:0] pb,
                        input logic [31:0] pj, input logic [31:0] ea, input logic [31:0] ei,
                        input logic [31:0] ep, input logic ev);
        exp_t e;
        bus.stallF    = sf;
        bus.stallD    = sd;
        bus.flushD    = fd;
        bus.pcSrcD    = ps;
        bus.jumpD     = jd;
        bus.pcBranchD = pb;
        bus.pcJumpD   = pj;
        sb.push_back('{addr: ea, instr: ei, pc4: ep, v: ev});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all(tag, e);
    endtask

    initial begin
        exp_t z;
        z = '{addr: 32'h0, instr: 32'h0, pc4: 32'h0, v: 1'b0};
        bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.pcSrcD = 0; bus.jumpD = 0;
        bus.pcBranchD = '0; bus.pcJumpD = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", z);
        rst = 1'b1;

        // Sequential fetch from reset PC.
        step("seq0", 0,0,0,0,0, 0, 0, 32'h04, 32'h2008_0005, 32'h04, 1);
        step("seq1", 0,0,0,0,0, 0, 0, 32'h08, mem_f(32'h04), 32'h08, 1);
        step("seq2", 0,0,0,0,0, 0, 0, 32'h0C, mem_f(32'h08), 32'h0C, 1);
        step("seq3", 0,0,0,0,0, 0, 0, 32'h10, mem_f(32'h0C), 32'h10, 1);

        // Taken branch with flush: one bubble, then target instruction.
        step("br",    0,0,1,1,0, 32'h40, 0, 32'h40, 32'h0, 32'h0, 0);
        step("br_tg", 0,0,0,0,0, 0, 0, 32'h44, mem_f(32'h40), 32'h44, 1);

        // Branch without flush, then jump that must beat a simultaneous branch.
        step("br2",    0,0,0,1,0, 32'h1000_0004, 0, 32'h1000_0004, mem_f(32'h44), 32'h48, 1);
        step("br2_tg", 0,0,0,0,0, 0, 0, 32'h1000_0008, mem_f(32'h1000_0004), 32'h1000_0008, 1);
        step("jmp",    0,0,1,1,1, 32'h40, 32'hF000_0100, 32'h1000_0100, 32'h0, 32'h0, 0);
        step("jmp_tg", 0,0,0,0,0, 0, 0, 32'h1000_0104, mem_f(32'h1000_0100), 32'h1000_0104, 1);

        // Full stall ignores flush and branch.
        step("stall0", 1,1,1,1,0, 32'h80, 0, 32'h1000_0104, mem_f(32'h1000_0100),
             32'h1000_0104, 1);
        step("stall1", 1,1,1,1,0, 32'h80, 0, 32'h1000_0104, mem_f(32'h1000_0100),
             32'h1000_0104, 1);
        step("resume", 0,0,0,0,0, 0, 0, 32'h1000_0108, mem_f(32'h1000_0104),
             32'h1000_0108, 1);

        // stallF alone: PC holds while IF/ID reloads from the same PC.
        step("stallf", 1,0,0,0,0, 0, 0, 32'h1000_0108, mem_f(32'h1000_0108),
             32'h1000_010C, 1);

        // Wrap of PC+4 at the top of the address space.
        step("wrap0", 0,0,0,1,0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, mem_f(32'h1000_0108),
             32'h1000_010C, 1);
        step("wrap1", 0,0,0,0,0, 0, 0, 32'h0, mem_f(32'hFFFF_FFFC), 32'h0, 1);
        step("post0", 0,0,0,0,0, 0, 0, 32'h04, 32'h2008_0005, 32'h04, 1);
        step("post1", 0,0,0,0,0, 0, 0, 32'h08, mem_f(32'h04), 32'h08, 1);

        // Asynchronous reset mid-cycle while stalled.
        bus.stallF = 1; bus.stallD = 1;
        #3 rst = 1'b0;
        #1;
        check_all("arst", z);
        @(posedge clk);
        #1;
        check_all("arst_hold", z);
        rst = 1'b1;
        step("rel", 0,0,0,0,0, 0, 0, 32'h04, 32'h2008_0005, 32'h04, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
